// File: rtl/bcd_pkg.sv
// Shared encodings for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/add3.sv
// Double-dabble digit correction: bias a digit >= 5 by 3 ahead of the next shift.
module add3
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    assign dout_c = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, registered results with
// a done pulse, leading-zero mask and overflow flag.
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [WIDTH-1:0]      A,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]     NZ,
    output logic                  OVF
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned TW = BW + WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t          state;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]    work;
    logic [CW-1:0]    cnt;
    logic             ovf_acc;

    logic [BW-1:0]    adj_c;
    logic [TW-1:0]    cat_c;
    logic [TW-1:0]    next_c;
    logic             carry_c;
    logic [BW-1:0]    work_next_c;
    logic [WIDTH-1:0] bin_next_c;
    logic [DIGITS-1:0] nz_c;
    logic             seen_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        add3 u_add3 (
            .din    (work[4*g +: 4]),
            .dout_c (adj_c[4*g +: 4])
        );
    end

    // Bit leaving the top digit marks a value beyond DIGITS decimal places.
    assign cat_c       = {adj_c, bin};
    assign carry_c     = cat_c[TW-1];
    assign next_c      = {cat_c[TW-2:0], 1'b0};
    assign work_next_c = next_c[TW-1 -: BW];
    assign bin_next_c  = next_c[WIDTH-1:0];

    // Blanking mask: a digit is shown once it or any more significant digit is nonzero.
    always_comb begin
        nz_c   = '0;
        seen_c = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            seen_c  = seen_c | (work_next_c[4*i +: 4] != 4'd0);
            nz_c[i] = seen_c;
        end
        nz_c[0] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            bin     <= '0;
            work    <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            BCD     <= '0;
            NZ      <= DIGITS'(1);
            OVF     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        bin     <= A;
                        work    <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                        BUSY    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin     <= bin_next_c;
                    work    <= work_next_c;
                    ovf_acc <= ovf_acc | carry_c;
                    cnt     <= cnt + CW'(1);
                    // Last bit: publish the result on the same edge that enters FIN.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                        BCD   <= work_next_c;
                        NZ    <= nz_c;
                        OVF   <= ovf_acc | carry_c;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq in three configurations: 8b/3 digits,
// 16b/5 digits and 8b/2 digits (overflow).
module tb_binary_to_bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [7:0]  a0 = '0, a2 = '0;
    logic [15:0] a1 = '0;
    logic        busy0, done0, ovf0;
    logic        busy1, done1, ovf1;
    logic        busy2, done2, ovf2;
    logic [11:0] bcd0;
    logic [19:0] bcd1;
    logic [7:0]  bcd2;
    logic [2:0]  nz0;
    logic [4:0]  nz1;
    logic [1:0]  nz2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .START(start0), .A(a0),
        .BUSY(busy0), .DONE(done0), .BCD(bcd0), .NZ(nz0), .OVF(ovf0)
    );

    binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .START(start1), .A(a1),
        .BUSY(busy1), .DONE(done1), .BCD(bcd1), .NZ(nz1), .OVF(ovf1)
    );

    binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .CLK(clk), .RESET_N(rst_n), .START(start2), .A(a2),
        .BUSY(busy2), .DONE(done2), .BCD(bcd2), .NZ(nz2), .OVF(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done0 : ((sel == 1) ? done1 : done2);
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy0 : ((sel == 1) ? busy1 : busy2);
    endfunction

    task automatic set_in(input int sel, input logic [15:0] val, input logic st);
        case (sel)
            0:       begin a0 = val[7:0]; start0 = st; end
            1:       begin a1 = val;      start1 = st; end
            default: begin a2 = val[7:0]; start2 = st; end
        endcase
    endtask

    // One conversion; edges counts rising edges from the accepting edge (inclusive)
    // up to the edge that raised DONE, busy_cyc the cycles with BUSY high.
    task automatic run(input int sel, input logic [15:0] val, output int edges, output int busy_cyc);
        @(negedge clk);
        set_in(sel, val, 1'b1);
        @(posedge clk);
        edges    = 1;
        busy_cyc = 0;
        #1 set_in(sel, ~val, 1'b0);
        @(negedge clk);
        while (!done_of(sel) && edges < 60) begin
            if (busy_of(sel)) busy_cyc++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (busy_of(sel)) busy_cyc++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int edges, busy_cyc, gap, idle, k;
        logic seen;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_bcd",  32'(bcd0),  32'h000);
        chk("rst_nz",   32'(nz0),   32'b001);
        chk("rst_ovf",  32'(ovf0),  32'd0);
        chk("rst_nz1",  32'(nz1),   32'b00001);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 255 on 8b/3 digits
        run(0, 16'd255, edges, busy_cyc);
        chk("c255_latency", 32'(edges), 32'd9);
        chk("c255_busy",    32'(busy_cyc), 32'd9);
        chk("c255_bcd",     32'(bcd0), 32'h255);
        chk("c255_nz",      32'(nz0),  32'b111);
        chk("c255_ovf",     32'(ovf0), 32'd0);
        @(negedge clk);
        chk("c255_done_pulse", 32'(done0), 32'd0);
        chk("c255_busy_off",   32'(busy0), 32'd0);

        // Zero and single-digit values
        run(0, 16'd0, edges, busy_cyc);
        chk("c0_bcd", 32'(bcd0), 32'h000);
        chk("c0_nz",  32'(nz0),  32'b001);
        chk("c0_ovf", 32'(ovf0), 32'd0);
        run(0, 16'd7, edges, busy_cyc);
        chk("c7_bcd", 32'(bcd0), 32'h007);
        chk("c7_nz",  32'(nz0),  32'b001);
        repeat (3) @(negedge clk);
        chk("c7_hold", 32'(bcd0), 32'h007);

        // START held high: back-to-back 200s, FIN-cycle START ignored
        @(negedge clk);
        a0 = 8'd200;
        start0 = 1'b1;
        k = 0;
        while (!done0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_first_done", 32'(done0), 32'd1);
        chk("b2b_first_bcd",  32'(bcd0), 32'h200);
        chk("b2b_first_nz",   32'(nz0),  32'b111);
        gap = 0;
        idle = 0;
        do begin
            @(negedge clk);
            gap++;
            if (!busy0) idle++;
        end while (!done0 && gap < 40);
        chk("b2b_gap",    32'(gap),  32'd10);
        chk("b2b_idle",   32'(idle), 32'd1);
        chk("b2b_second_bcd", 32'(bcd0), 32'h200);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_stop", 32'(busy0), 32'd0);

        // Reset in the 4th SHIFT cycle of a 99 conversion
        @(negedge clk);
        a0 = 8'd99;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_bcd",  32'(bcd0),  32'h000);
        chk("abort_nz",   32'(nz0),   32'b001);
        chk("abort_ovf",  32'(ovf0),  32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
            if (busy0) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(0, 16'd42, edges, busy_cyc);
        chk("c42_latency", 32'(edges), 32'd9);
        chk("c42_bcd", 32'(bcd0), 32'h042);
        chk("c42_nz",  32'(nz0),  32'b011);

        // 16b/5 digits full scale
        run(1, 16'd65535, edges, busy_cyc);
        chk("w16_latency", 32'(edges), 32'd17);
        chk("w16_bcd", 32'(bcd1), 32'h65535);
        chk("w16_nz",  32'(nz1),  32'b11111);
        chk("w16_ovf", 32'(ovf1), 32'd0);

        // 8b/2 digits: overflow keeps value mod 100
        run(2, 16'd255, edges, busy_cyc);
        chk("d2_255_bcd", 32'(bcd2), 32'h55);
        chk("d2_255_ovf", 32'(ovf2), 32'd1);
        run(2, 16'd99, edges, busy_cyc);
        chk("d2_99_bcd", 32'(bcd2), 32'h99);
        chk("d2_99_ovf", 32'(ovf2), 32'd0);
        run(2, 16'd100, edges, busy_cyc);
        chk("d2_100_bcd", 32'(bcd2), 32'h00);
        chk("d2_100_nz",  32'(nz2),  32'b01);
        chk("d2_100_ovf", 32'(ovf2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
